// File: rtl/scr1_tb_ahb_mem_mp.sv
// Multi-port AHB-Lite slave test memory for SCR1 benches.
// NPORTS independent slave ports share one byte array; each port has its own
// wait-state count and a round-robin arbiter serialises array accesses.
// Optional feature macro: SCR1_TB_AHB_MEM_RND_STALL_EN (per-port LFSR stalls).

module scr1_tb_ahb_mem_mp_port #(
  parameter int MEM_POWER_SIZE = 20,
  parameter int STALL_W        = 8
`ifdef SCR1_TB_AHB_MEM_RND_STALL_EN
  , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall_i,
  input  logic [1:0]                htrans_i,
  input  logic [2:0]                hsize_i,
  input  logic [31:0]               haddr_i,
  input  logic                      hwrite_i,
  input  logic                      gnt_i,
  input  logic [31:0]               rword_i,
  output logic                      req_o,
  output logic [MEM_POWER_SIZE-1:0] addr_o,
  output logic [2:0]                size_o,
  output logic                      write_o,
  output logic                      hready_o,
  output logic                      hresp_o,
  output logic [31:0]               hrdata_o
);
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ARB, ST_ERR1, ST_ERR2} state_t;

  state_t                    state_q;
  logic [STALL_W-1:0]        cnt_q, cnt_d;
  logic [MEM_POWER_SIZE-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      write_q, hready_q, hresp_q;
  logic [31:0]               hrdata_q;
  logic                      accept, illegal, oor;
  logic                      unused_htrans0;

  // only bit 1 matters: NONSEQ/SEQ start a transfer, IDLE/BUSY are ignored
  assign unused_htrans0 = htrans_i[0];
  assign accept  = hready_q & htrans_i[1];
  assign oor     = (haddr_i >> MEM_POWER_SIZE) != 32'd0;
  assign illegal = (hsize_i > 3'd2) | ((hsize_i == 3'd1) & haddr_i[0]) |
                   ((hsize_i == 3'd2) & (haddr_i[1:0] != 2'b00)) | oor;

`ifdef SCR1_TB_AHB_MEM_RND_STALL_EN
  logic [15:0] lfsr_q;
  // x^16+x^14+x^13+x^11+1 LFSR, stepped once per accepted address phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lfsr_q <= LFSR_SEED;
    else if (accept) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  // MSB of stall_i selects a random count masked by the remaining bits
  assign cnt_d = stall_i[STALL_W-1] ? {1'b0, lfsr_q[STALL_W-2:0] & stall_i[STALL_W-2:0]} : stall_i;
`else
  assign cnt_d = stall_i;
`endif

  // per-port transfer FSM; outputs are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_q <= cnt_q - STALL_W'(1);
          if (cnt_q == STALL_W'(1)) state_q <= ST_ARB;
        end
        ST_ARB: if (gnt_i) begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (!write_q) hrdata_q <= rword_i;
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
        end
        ST_ERR2: begin
          state_q <= ST_IDLE;
          hresp_q <= 1'b0;
        end
        default: ;
      endcase
      // hready is high only in IDLE/ERR2, so an accept overrides those moves
      if (accept) begin
        addr_q   <= haddr_i[MEM_POWER_SIZE-1:0];
        size_q   <= hsize_i;
        write_q  <= hwrite_i;
        hready_q <= 1'b0;
        if (illegal) begin
          state_q <= ST_ERR1;
          hresp_q <= 1'b1;
        end else begin
          hresp_q <= 1'b0;
          cnt_q   <= cnt_d;
          state_q <= (cnt_d == '0) ? ST_ARB : ST_WAIT;
        end
      end
    end
  end

  assign req_o    = (state_q == ST_ARB);
  assign addr_o   = addr_q;
  assign size_o   = size_q;
  assign write_o  = write_q;
  assign hready_o = hready_q;
  assign hresp_o  = hresp_q;
  assign hrdata_o = hrdata_q;
endmodule

module scr1_tb_ahb_mem_mp #(
  parameter int NPORTS         = 2,
  parameter int MEM_POWER_SIZE = 20,
  parameter int STALL_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS*STALL_W-1:0] stall_in,
  input  logic [NPORTS*2-1:0]       htrans,
  input  logic [NPORTS*3-1:0]       hsize,
  input  logic [NPORTS*32-1:0]      haddr,
  input  logic [NPORTS-1:0]         hwrite,
  input  logic [NPORTS*32-1:0]      hwdata,
  output logic [NPORTS-1:0]         hready,
  output logic [NPORTS*32-1:0]      hrdata,
  output logic [NPORTS-1:0]         hresp
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [7:0] mem [0:(2**MEM_POWER_SIZE)-1];

  logic [NPORTS-1:0]                      req, wr_p;
  logic [NPORTS-1:0][MEM_POWER_SIZE-1:0]  addr_p;
  logic [NPORTS-1:0][2:0]                 size_p;
  logic [NPORTS-1:0][31:0]                wdata_p;
  logic [PW-1:0]                          ptr_q, win, idx;
  logic                                   gnt_any;
  logic [MEM_POWER_SIZE-1:0]              g_addr;
  logic [MEM_POWER_SIZE-3:0]              g_wb;
  logic [31:0]                            g_wdata, rword;
  logic [3:0]                             be;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign wdata_p[p] = hwdata[p*32 +: 32];
    scr1_tb_ahb_mem_mp_port #(
      .MEM_POWER_SIZE (MEM_POWER_SIZE),
      .STALL_W        (STALL_W)
`ifdef SCR1_TB_AHB_MEM_RND_STALL_EN
      , .LFSR_SEED    (16'hACE1 + 16'(p))
`endif
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .stall_i  (stall_in[p*STALL_W +: STALL_W]),
      .htrans_i (htrans[p*2 +: 2]),
      .hsize_i  (hsize[p*3 +: 3]),
      .haddr_i  (haddr[p*32 +: 32]),
      .hwrite_i (hwrite[p]),
      .gnt_i    (gnt_any && (win == PW'(p))),
      .rword_i  (rword),
      .req_o    (req[p]),
      .addr_o   (addr_p[p]),
      .size_o   (size_p[p]),
      .write_o  (wr_p[p]),
      .hready_o (hready[p]),
      .hresp_o  (hresp[p]),
      .hrdata_o (hrdata[p*32 +: 32])
    );
  end

  // round-robin search starting at ptr_q; first requester wins
  always_comb begin
    gnt_any = 1'b0;
    win     = '0;
    idx     = ptr_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        win     = idx;
      end
      idx = (idx == PW'(NPORTS-1)) ? '0 : idx + PW'(1);
    end
  end

  // pointer moves to the port after each winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr_q <= '0;
    else if (gnt_any) ptr_q <= (win == PW'(NPORTS-1)) ? '0 : win + PW'(1);
  end

  assign g_addr  = addr_p[win];
  assign g_wb    = g_addr[MEM_POWER_SIZE-1:2];
  assign g_wdata = wdata_p[win];
  assign rword   = {mem[{g_wb, 2'd3}], mem[{g_wb, 2'd2}], mem[{g_wb, 2'd1}], mem[{g_wb, 2'd0}]};

  // byte lanes follow AHB little-endian lane placement
  always_comb begin
    case (size_p[win])
      3'd0:    be = 4'b0001 << g_addr[1:0];
      3'd1:    be = g_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // array write for the granted port; contents survive rst, pending writes do not
  always_ff @(posedge clk) begin
    if (!rst && gnt_any && wr_p[win])
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[{g_wb, 2'(k)}] <= g_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_scr1_tb_ahb_mem_mp.sv
// Scoreboard bench for scr1_tb_ahb_mem_mp with four ports.
module tb_scr1_tb_ahb_mem_mp;
  localparam int NP = 4, MP = 20, SW = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic [NP*SW-1:0] stall_in = '0;
  logic [NP*2-1:0]  htrans = '0;
  logic [NP*3-1:0]  hsize = '0;
  logic [NP*32-1:0] haddr = '0;
  logic [NP-1:0]    hwrite = '0;
  logic [NP*32-1:0] hwdata = '0;
  logic [NP-1:0]    hready, hresp;
  logic [NP*32-1:0] hrdata;

  always #5 clk = ~clk;

  scr1_tb_ahb_mem_mp #(.NPORTS(NP), .MEM_POWER_SIZE(MP), .STALL_W(SW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .htrans(htrans), .hsize(hsize),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hrdata(hrdata), .hresp(hresp));

  typedef struct { bit err; bit rd; logic [31:0] data; logic [31:0] mask; int lat; } exp_t;
  typedef struct { bit wr; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; int stall; } op_t;

  exp_t expq [NP][$];
  bit [7:0] mdl [bit [31:0]];
  int mptr = 0;
  op_t rop [NP];
  bit  ren [NP];
  int  checks = 0, errors = 0;
  int  lowcnt [NP];
  bit  hrlow [NP];

  task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port%0d: got %h expected %h at %0t", nm, p, act, exp, $time);
    end
  endtask

  function automatic bit illegal(input op_t o);
    return (o.size > 3'd2) || (o.size == 3'd1 && o.addr[0]) ||
           (o.size == 3'd2 && o.addr[1:0] != 2'b00) || (o.addr >= (32'd1 << MP));
  endfunction

  // apply one granted transfer to the byte model and record the response
  function automatic void grant(input int q, input int t);
    exp_t e;
    bit [31:0] a, base;
    e.err = 1'b0; e.rd = !rop[q].wr; e.lat = t; e.data = '0; e.mask = '0;
    if (rop[q].wr) begin
      for (int k = 0; k < (1 << rop[q].size); k++) begin
        a = rop[q].addr + 32'(k);
        mdl[a] = rop[q].wdata[8*int'(a[1:0]) +: 8];
      end
    end else begin
      base = rop[q].addr & ~32'd3;
      for (int k = 0; k < 4; k++)
        if (mdl.exists(base + 32'(k))) begin
          e.data[8*k +: 8] = mdl[base + 32'(k)];
          e.mask[8*k +: 8] = 8'hFF;
        end
    end
    expq[q].push_back(e);
  endfunction

  // all enabled ops start together; a legal op can be granted stall+1 cycles
  // after acceptance, one grant per cycle in round-robin order from mptr
  function automatic void model_round();
    int rt [NP];
    bit pend [NP];
    int left, t, q;
    exp_t e;
    left = 0;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0;
      rt[p] = 0;
      if (ren[p]) begin
        if (illegal(rop[p])) begin
          e.err = 1'b1; e.rd = 1'b0; e.data = '0; e.mask = '0; e.lat = 1;
          expq[p].push_back(e);
        end else begin
          pend[p] = 1'b1; rt[p] = rop[p].stall + 1; left++;
        end
      end
    end
    t = 1;
    while (left > 0) begin
      for (int i = 0; i < NP; i++) begin
        q = (mptr + i) % NP;
        if (pend[q] && rt[q] <= t) begin
          grant(q, t);
          pend[q] = 1'b0; left--; mptr = (q + 1) % NP;
          break;
        end
      end
      t++;
    end
  endfunction

  // monitor: a port's response is the first sample with hready high after low ones
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (rst) begin
          lowcnt[p] = 0; hrlow[p] = 1'b0;
        end else if (!hready[p]) begin
          lowcnt[p]++; hrlow[p] = hresp[p];
        end else if (lowcnt[p] > 0) begin
          if (expq[p].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp port%0d: got response expected none", p);
          end else begin
            e = expq[p].pop_front();
            chk("latency", p, 32'(lowcnt[p]), 32'(e.lat));
            chk("hresp", p, {31'd0, hresp[p]}, {31'd0, e.err});
            chk("hresp_wait", p, {31'd0, hrlow[p]}, {31'd0, e.err});
            if (e.rd && !e.err)
              chk("rdata", p, hrdata[p*32 +: 32] & e.mask, e.data & e.mask);
          end
          lowcnt[p] = 0;
        end
      end
    end
  end

  task automatic drive_addr(input int p, input op_t o);
    htrans[p*2 +: 2]     = 2'b10;
    hsize[p*3 +: 3]      = o.size;
    haddr[p*32 +: 32]    = o.addr;
    hwrite[p]            = o.wr;
    stall_in[p*SW +: SW] = SW'(o.stall);
  endtask

  task automatic wait_all();
    int n = 0;
    while (hready != '1 && n < 200) begin @(negedge clk); n++; end
    if (hready != '1) begin
      checks++; errors++;
      $display("FAIL timeout: hready %b expected all ones", hready);
    end
  endtask

  task automatic round();
    model_round();
    @(negedge clk);
    for (int p = 0; p < NP; p++)
      if (ren[p]) drive_addr(p, rop[p]); else htrans[p*2 +: 2] = 2'b00;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      htrans[p*2 +: 2] = 2'b00;
      if (ren[p]) hwdata[p*32 +: 32] = rop[p].wdata;
    end
    wait_all();
  endtask

  task automatic one(input int p, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input int st);
    for (int i = 0; i < NP; i++) ren[i] = 1'b0;
    rop[p].wr = wr; rop[p].size = sz; rop[p].addr = a; rop[p].wdata = d; rop[p].stall = st;
    ren[p] = 1'b1;
    round();
  endtask

  task automatic check_reset_vals();
    chk("rst_hready", 0, 32'(hready), 32'(4'hF));
    chk("rst_hresp", 0, 32'(hresp), 32'd0);
    for (int p = 0; p < NP; p++) chk("rst_hrdata", p, hrdata[p*32 +: 32], 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; #1;
    check_reset_vals();
    @(negedge clk); rst = 1'b0;
    mptr = 0;
    for (int p = 0; p < NP; p++) expq[p].delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // zero stall word write/read
    one(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    one(0, 0, 3'd2, 32'h100, 32'h0, 0);
    chk("deadbeef", 0, hrdata[31:0], 32'hDEADBEEF);

    // byte lanes
    one(0, 1, 3'd2, 32'h200, 32'h11223344, 0);
    one(0, 1, 3'd0, 32'h201, 32'hAAAAAAAA, 1);
    one(0, 1, 3'd1, 32'h202, 32'hBBCCBBCC, 2);
    one(0, 0, 3'd2, 32'h200, 32'h0, 0);
    chk("lanes", 0, hrdata[31:0], 32'hBBCCAA44);

    // stall=3 on port 1 followed by back-to-back NONSEQ in the hready cycle
    for (int i = 0; i < NP; i++) ren[i] = 1'b0;
    rop[1].wr = 1'b0; rop[1].size = 3'd2; rop[1].addr = 32'h100; rop[1].wdata = '0; rop[1].stall = 3;
    ren[1] = 1'b1;
    model_round();
    @(negedge clk); drive_addr(1, rop[1]);
    @(negedge clk); htrans[3:2] = 2'b00;
    n = 0;
    while (!hready[1] && n < 100) begin @(negedge clk); n++; end
    rop[1].addr = 32'h200;
    model_round();
    drive_addr(1, rop[1]);
    @(negedge clk); htrans[3:2] = 2'b00;
    chk("b2b_nogap", 1, {31'd0, hready[1]}, 32'd0);
    wait_all();

    // reset in the middle of a stalled read
    @(negedge clk);
    rop[0].wr = 1'b0; rop[0].size = 3'd2; rop[0].addr = 32'h100; rop[0].stall = 5;
    drive_addr(0, rop[0]);
    @(negedge clk); htrans[1:0] = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1; #1;
    check_reset_vals();
    @(negedge clk); rst = 1'b0; mptr = 0;
    one(0, 1, 3'd2, 32'h40, 32'hCAFEF00D, 5);
    one(0, 0, 3'd2, 32'h40, 32'h0, 5);
    chk("after_rst", 0, hrdata[31:0], 32'hCAFEF00D);

    // contention: all four read together twice after reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        ren[p] = 1'b1; rop[p].wr = 1'b0; rop[p].size = 3'd2; rop[p].stall = 0;
        rop[p].addr = (p % 2 == 0) ? 32'h100 : 32'h200; rop[p].wdata = '0;
      end
      round();
    end

    // error responses, memory must stay intact
    one(0, 0, 3'd2, 32'h102, 32'h0, 0);
    one(0, 1, 3'd2, 32'h102, 32'h55555555, 0);
    one(0, 1, 3'd3, 32'h100, 32'h66666666, 0);
    one(0, 1, 3'd2, 32'h0010_0100, 32'h77777777, 0);
    one(0, 0, 3'd2, 32'h0010_0000, 32'h0, 2);
    one(0, 0, 3'd2, 32'h100, 32'h0, 0);
    chk("err_nomod", 0, hrdata[31:0], 32'hDEADBEEF);

    // randomized multi-port rounds
    for (int r = 0; r < 150; r++) begin
      for (int p = 0; p < NP; p++) begin
        ren[p] = ($urandom_range(0, 3) != 0);
        rop[p].wr = $urandom_range(0, 1) == 1;
        rop[p].wdata = $urandom;
        rop[p].stall = $urandom_range(0, 4);
        rop[p].size = 3'($urandom_range(0, 2));
        rop[p].addr = 32'h300 + 32'($urandom_range(0, 63));
        rop[p].addr = rop[p].addr & ~((32'd1 << rop[p].size) - 32'd1);
        case ($urandom_range(0, 15))
          0: rop[p].size = 3'($urandom_range(3, 7));
          1: begin rop[p].size = 3'd2; rop[p].addr = rop[p].addr | 32'd1; end
          2: rop[p].addr = rop[p].addr | 32'h0010_0000;
          default: ;
        endcase
      end
      round();
    end

    repeat (5) @(negedge clk);
    for (int p = 0; p < NP; p++) chk("queue_empty", p, 32'(expq[p].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scr1_tb_ahb_mem_mp.md
# scr1_tb_ahb_mem_mp

Parametrised multi-port AHB-Lite slave memory model for SCR1 testbenches. It generalises the single imem/dmem test memory to NPORTS independent AHB-Lite slave ports sharing one byte-addressable array. Each port has its own programmable wait-state count, and ports are served by a round-robin arbiter. Misaligned, oversized and out-of-range accesses get an AHB ERROR response. It sits between the core (or several masters) and the testbench top.

## Interface
- NPORTS, 2: number of AHB-Lite slave ports (1..8).
- MEM_POWER_SIZE, 20: memory size is 2^MEM_POWER_SIZE bytes.
- STALL_W, 8: width of the per-port wait-state count.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  NPORTS*STALL_W  per-port extra wait states, sampled at address phase.
- htrans  in  NPORTS*2  AHB HTRANS per port.
- hsize  in  NPORTS*3  AHB HSIZE per port.
- haddr  in  NPORTS*32  AHB HADDR per port.
- hwrite  in  NPORTS  AHB HWRITE per port.
- hwdata  in  NPORTS*32  AHB HWDATA per port, valid in data phase.
- hready  out  NPORTS  AHB HREADYOUT per port, registered.
- hrdata  out  NPORTS*32  read data per port, registered.
- hresp  out  NPORTS  AHB HRESP per port (1 = ERROR), registered.

Port p uses slice [p*W +: W] of every vector.

## Operation
- Per-port FSM with states IDLE, WAIT, ARB, ERR1 and ERR2.
- Address phase accepted at an edge where hready[p]=1 and htrans[p][1]=1 (NONSEQ or SEQ). IDLE and BUSY are ignored.
- On accept, the port latches addr, size, write and stall count, and drives hready=0.
  - Legal access: go to WAIT, or straight to ARB if stall=0.
  - Illegal access: go to ERR1.
- Illegal access is any of:
  - hsize>2;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= 2^MEM_POWER_SIZE.
- WAIT: decrement the counter each cycle; move to ARB when it reaches 0.
- ARB: raise a request to the round-robin arbiter. Exactly one port is granted per cycle.
  - Grant pointer advances to the port after the winner.
  - Pointer resets to port 0.
- At the granted edge:
  - Read: registers the full aligned word into hrdata.
  - Write: updates only the byte lanes selected by size and addr[1:0], using hwdata from that cycle.
  - Then hready=1, hresp=0, state IDLE.
- ERR1: drive hresp=1, hready=0 for one cycle, then ERR2.
- ERR2: drive hresp=1, hready=1, then IDLE. Memory is not modified.
- hrdata holds its last value while the port is idle.
- Memory contents are not cleared by rst. The array is loaded by the testbench (hierarchical $readmemh).

## Timing
- Reset values (async on rst=1): hready=all 1, hresp=all 0, hrdata=all 0, every FSM in IDLE, grant pointer 0.
- Latency with stall=s and no contention:
  - address accepted at edge E0;
  - hready low for s+1 cycles;
  - hready=1 after edge E(s+1);
  - transfer completes at E(s+2).
- Minimum is one wait state.
- Contention: k ports in ARB in the same cycle are served over k consecutive cycles in round-robin order. A losing port stays in ARB with hready=0.
- Back-to-back: a new address phase presented during the hready=1 cycle is accepted at the completion edge with no idle cycle.
- Error timing: 1 cycle hresp=1/hready=0, then 1 cycle hresp=1/hready=1.
- Concurrent writes to the same byte are serialised by grant order; the last granted write wins.
- Read-after-write across ports: a read granted after a write returns the new data.
- rst asserted mid-transfer aborts all transfers immediately and drops pending writes. Outputs return to reset values in the same cycle.
- stall_in changes during WAIT have no effect on the transfer in flight.

## Configuration
- SCR1_TB_AHB_MEM_RND_STALL_EN
  - Defined: each port has a 16-bit maximal-length LFSR (seed 16'hACE1 + p, reset by rst) advanced once per accepted address phase. When stall_in[p] has its MSB set, the wait count is LFSR[STALL_W-2:0] AND stall_in[p][STALL_W-2:0] instead of the raw value.
  - Not defined: stall_in is always used as the literal wait count, and no LFSR logic exists.

## Test plan
- Reset: rst=1 mid-read on port 0 with stall=5 -> next cycle hready=1, hresp=0, hrdata=0; a subsequent write to 0x40 with stall=5 completes normally.
- Zero stall, port 0: write word 0xDEADBEEF to 0x100, then read 0x100 -> hready low exactly 1 cycle each, read returns 0xDEADBEEF.
- Byte lanes: word write 0x11223344 to 0x200, byte write 0xAA to 0x201, halfword write 0xBBCC to 0x202 -> read 0x200 returns 0xBBCCAA44.
- Stall count: port 1 stall=3 read -> hready low for exactly 4 cycles; back-to-back NONSEQ accepted with no gap.
- Contention: NPORTS=4, all ports read simultaneously with stall=0 after reset -> completions on consecutive cycles in order 0,1,2,3; the next simultaneous round starts at port 0 again.
- Errors: word read at 0x102, hsize=3, and addr 0x0010_0000 (MEM_POWER_SIZE=20) -> each gives the two-cycle ERROR (hresp=1/hready=0, then hresp=1/hready=1), and memory is unchanged.
